// File: rtl/rr_grant_ctrl_pkg.sv
// Shared types and helpers for the round-robin grant controller.
package rr_grant_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BUSY = 2'd2
  } state_t;

  // A timeout of zero means the owner may hold the resource indefinitely.
  localparam int TIMEOUT_OFF = 0;

  function automatic int clog2_min1(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << bits) < value) bits = bits + 1;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

  function automatic int cnt_width(input int timeout_cycles);
    return clog2_min1(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/rr_grant_ctrl_pick.sv
// Rotating priority encoder: first set request at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int WIDTH = 4,
  parameter int PW    = 2
) (
  input  logic [WIDTH-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [WIDTH-1:0] win,
  output logic [PW-1:0]    idx,
  output logic             any
);

  int j;

  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < WIDTH; i++) begin
      j = int'(ptr) + i;
      if (j >= WIDTH) j = j - WIDTH;
      if (!any && req[j]) begin
        any    = 1'b1;
        win[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: arbitrate, present grant with load until ack,
// then hold ownership until done, request withdrawal or hold timeout.
module rr_grant_ctrl
  import rr_grant_ctrl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             ack,
  input  logic             done,
  output logic [WIDTH-1:0] gnt,
  output logic             load,
  output logic             busy,
  output logic             timeout
);

  localparam int PW = clog2_min1(WIDTH);
  localparam int CW = cnt_width(TIMEOUT);
  localparam bit TO_EN = (TIMEOUT != TIMEOUT_OFF);
  localparam logic [CW-1:0] CNT_LAST = CW'(TO_EN ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [PW-1:0] IDX_LAST = PW'(WIDTH - 1);

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    owner;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pick_win;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;
  logic             owner_req;
  logic             expire;
  logic             release_now;

  rr_pick #(.WIDTH(WIDTH), .PW(PW)) u_pick (
    .req (req),
    .ptr (ptr),
    .win (pick_win),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign owner_req   = req[owner];
  assign expire      = TO_EN && (cnt == CNT_LAST);
  assign release_now = done || !owner_req || expire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gnt     <= '0;
      load    <= 1'b0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      ptr     <= '0;
      owner   <= '0;
      cnt     <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          gnt <= '0;
          if (pick_any) begin
            gnt   <= pick_win;
            owner <= pick_idx;
            load  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          // ack beats a dropped request: downstream has already captured gnt.
          if (ack) begin
            load  <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= BUSY;
          end else if (!owner_req) begin
            load  <= 1'b0;
            gnt   <= '0;
            state <= IDLE;
          end
        end
        BUSY: begin
          cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
          if (release_now) begin
            busy    <= 1'b0;
            gnt     <= '0;
            ptr     <= (owner == IDX_LAST) ? '0 : owner + 1'b1;
            timeout <= expire && !done && owner_req;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          load  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Self-checking bench for rr_grant_ctrl (WIDTH=4, TIMEOUT=3) with a grant scoreboard.
module tb_rr_grant_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic       done;
  logic [3:0] gnt;
  logic       load;
  logic       busy;
  logic       timeout;

  int         errors = 0;
  int         checks = 0;
  int         to_pulses = 0;
  logic       prev_load = 1'b0;
  logic [3:0] exp_q[$];
  logic [3:0] e;

  rr_grant_ctrl #(.WIDTH(4), .TIMEOUT(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ack     (ack),
    .done    (done),
    .gnt     (gnt),
    .load    (load),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every new load presentation must match the next expected grant.
  always @(negedge clk) begin
    if (!rst) begin
      prev_load = 1'b0;
    end else begin
      if (load && !prev_load) begin
        if (exp_q.size() == 0) begin
          chk("gnt_unexpected", 32'(gnt), 'h0);
        end else begin
          e = exp_q.pop_front();
          chk("gnt_seq", 32'(gnt), 32'(e));
        end
      end
      if (timeout) to_pulses++;
      prev_load = load;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  logic [3:0] lreq[6];
  logic [3:0] lexp[6];

  initial begin
    lreq = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0011, 4'b1000};
    lexp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b1000};
    rst = 1'b0; req = '0; ack = 1'b0; done = 1'b0;
    #2;
    chk("rst_gnt", 32'(gnt), 'h0);
    chk("rst_load", 32'(load), 'h0);
    chk("rst_busy", 32'(busy), 'h0);
    chk("rst_timeout", 32'(timeout), 'h0);
    step(); step();
    rst = 1'b1;
    step();

    // Single requester, zero-wait ack.
    req = 4'b0010; ack = 1'b1;
    exp_q.push_back(4'b0010);
    step();
    chk("a_load", 32'(load), 'h1);
    step();
    chk("a_load_one_cycle", 32'(load), 'h0);
    chk("a_busy", 32'(busy), 'h1);
    step();
    chk("a_busy_hold", 32'(busy), 'h1);
    done = 1'b1;
    step();
    chk("a_rel_gnt", 32'(gnt), 'h0);
    chk("a_rel_busy", 32'(busy), 'h0);
    done = 1'b0; req = '0;
    step();

    // ptr=2 after owner 1: 0011 wraps to requester 0.
    req = 4'b0011;
    exp_q.push_back(4'b0001);
    step(); step();
    done = 1'b1;
    step();
    done = 1'b0; req = '0;
    step();

    // Asynchronous reset in the middle of BUSY.
    req = 4'b0100;
    exp_q.push_back(4'b0100);
    step(); step();
    chk("r_busy_pre", 32'(busy), 'h1);
    chk("r_gnt_pre", 32'(gnt), 'h4);
    #1 rst = 1'b0;
    #1;
    chk("r_async_gnt", 32'(gnt), 'h0);
    chk("r_async_busy", 32'(busy), 'h0);
    chk("r_async_load", 32'(load), 'h0);
    req = 4'b1111;
    step();
    rst = 1'b1;

    // Rotation from ptr=0, then wrap checks with 0011 and a final 1000.
    for (int i = 0; i < 6; i++) begin
      req = lreq[i];
      exp_q.push_back(lexp[i]);
      step();
      chk("rot_load", 32'(load), 'h1);
      step();
      chk("rot_busy", 32'(busy), 'h1);
      done = 1'b1;
      step();
      chk("rot_rel_gnt", 32'(gnt), 'h0);
      done = 1'b0;
    end
    req = '0;
    step();

    // Abort: request drops while waiting for ack.
    req = 4'b0100; ack = 1'b0;
    exp_q.push_back(4'b0100);
    step();
    step();
    chk("ab_load_held", 32'(load), 'h1);
    req = '0;
    step();
    chk("ab_gnt", 32'(gnt), 'h0);
    chk("ab_load", 32'(load), 'h0);
    chk("ab_busy", 32'(busy), 'h0);
    step();

    // Timeout: ptr still 0 after the abort, so 0101 grants 0001 first.
    req = 4'b0101; ack = 1'b1;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0100);
    step();
    step();
    chk("to_busy_t", 32'(busy), 'h1);
    step();
    step();
    chk("to_busy_t2", 32'(busy), 'h1);
    chk("to_no_early", 32'(timeout), 'h0);
    step();
    chk("to_gnt", 32'(gnt), 'h0);
    chk("to_pulse", 32'(timeout), 'h1);
    step();
    chk("to_pulse_end", 32'(timeout), 'h0);
    chk("to_next_load", 32'(load), 'h1);
    step();
    done = 1'b1;
    step();
    done = 1'b0; req = '0;
    step();

    // ack and request drop together: ack wins, then release on withdrawal.
    req = 4'b0010;
    exp_q.push_back(4'b0010);
    step();
    req = '0;
    step();
    chk("aw_busy", 32'(busy), 'h1);
    step();
    chk("aw_gnt", 32'(gnt), 'h0);
    chk("aw_no_timeout", 32'(timeout), 'h0);
    ack = 1'b0;
    step(); step();

    chk("q_empty", 32'(exp_q.size()), 'h0);
    chk("timeout_pulses", 32'(to_pulses), 'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_grant_ctrl.md
# rr_grant_ctrl

Round-robin grant controller that shares one downstream resource among `WIDTH` requesters and sequences the grant register that sits in front of it. Picks the next requester in rotating priority order, presents a one-hot grant with a `load` strobe held until the downstream `ack`, then holds ownership until the owner releases, withdraws its request or exceeds a hold timeout. Sits between the raw request lines and the grant/decoder register stage of the arbiter datapath.

## Interface
- `WIDTH`, 4: number of requesters; ≥ 2.
- `TIMEOUT`, 15: maximum BUSY cycles per grant; 0 disables the timeout.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  WIDTH  request lines, level-sensitive, one per requester.
- `ack`  in  1  downstream accepted the grant presented with `load`.
- `done`  in  1  current owner releases the resource; only sampled in BUSY.
- `gnt`  out  WIDTH  registered one-hot grant; all-zero when nobody owns.
- `load`  out  1  high in LOAD state; downstream captures `gnt` on `load & ack`.
- `busy`  out  1  high in BUSY state.
- `timeout`  out  1  one-cycle pulse on forced release.

## Operation
- Reset values: state IDLE, `gnt`=0, `load`=0, `busy`=0, `timeout`=0, priority pointer `ptr`=0, hold counter `cnt`=0.
- Arbitration: search `req` from index `ptr` upward, wrapping `WIDTH-1`→0; first set bit wins. `ptr` is the index after the last completed grant, mod `WIDTH`.
- IDLE: if `|req`, register winner one-hot into `gnt`, go LOAD. Else stay, `gnt`=0.
- LOAD: `load`=1. On `ack` → BUSY, `cnt`=0. If `ack`=0 and owner's `req` bit is 0 → IDLE, `gnt`=0, `ptr` unchanged (abort). `ack` and request drop in the same cycle: `ack` wins (→ BUSY), since downstream has captured.
- BUSY: `busy`=1, `cnt` increments each cycle. Release when `done`=1, or owner's `req` bit is 0, or (`TIMEOUT`≠0 and `cnt`==`TIMEOUT-1`). On release → IDLE, `gnt`=0, `ptr` = owner index+1 mod `WIDTH`. `timeout` pulses only when release is solely due to the counter; `done` in the same cycle as expiry is a normal release.
- `cnt` width: clog2(`TIMEOUT`+1), minimum 1 bit; saturates, never wraps.
- `gnt` is always zero or exactly one-hot; never changes outside the IDLE→LOAD, LOAD→IDLE and BUSY→IDLE transitions.

## Timing
- `req` asserted in IDLE at edge t → `gnt` and `load` valid after edge t+1 (1-cycle latency).
- `ack` sampled with `load`; zero-wait `ack` gives exactly one `load` cycle.
- Release sampled at edge t → `gnt`=0 after t; earliest next `gnt` after t+1 (one idle cycle between owners).
- Timeout: with `ack` at edge t, forced release at edge t+`TIMEOUT`; `timeout` high for the following cycle.
- Reset asserted in any state clears all outputs immediately (asynchronous), including mid-LOAD and mid-BUSY; first arbitration after deassertion starts at index 0.

## Structure
- Shared package: state enum (IDLE, LOAD, BUSY), clog2 function, encoding constants for the hold counter.
- One sub-module: `rr_pick`, combinational rotating priority encoder (`req`, `ptr` → one-hot winner, winner index, `any`). Controller holds FSM, `ptr`, `cnt`, output registers.

## Test plan
- Reset mid-BUSY with `gnt`=0100: pull `rst` low → `gnt`=0000, `busy`=0, `load`=0 without a clock edge; after release `req`=1111 grants 0001.
- Single `req`=0010 in IDLE, `ack` tied high → `gnt`=0010 and `load`=1 for one cycle, then `busy`=1 until `done`, then `gnt`=0000 next cycle.
- `req`=1111 held, `ack` high, `done` one cycle after each BUSY entry → grant sequence 0001, 0010, 0100, 1000, 0001.
- After grant 1000 completes (`ptr`=0) versus after grant 0010 (`ptr`=2), `req`=0011 → grants 0001 and 0001 respectively (wrap-around checked).
- `TIMEOUT`=3, `req`=0101 held, no `done` → grant 0001 force-released 3 cycles after `ack`, `timeout` pulses once, next grant 0100.
- `req`=0100 asserted, `ack` held low, then `req` dropped in LOAD → IDLE, `gnt`=0000, no `busy`, `ptr` unchanged; next `req`=0100 granted again.
